// File: rtl/seven_seg_scan_ctrl_if.sv
// Write port of the 7-segment scan controller: one display value (hex nibbles
// plus decimal points) offered with a valid/ready handshake.
interface seven_seg_scan_ctrl_if #(
    parameter int NUM_DIGITS = 4
);
    logic                      wr_valid;
    logic                      wr_ready;
    logic [4*NUM_DIGITS-1:0]   wr_data;
    logic [NUM_DIGITS-1:0]     wr_dp;

    // Producer side: offers values and watches ready.
    modport master (
        output wr_valid,
        output wr_data,
        output wr_dp,
        input  wr_ready
    );

    // Controller side: accepts values and reports ready.
    modport slave (
        input  wr_valid,
        input  wr_data,
        input  wr_dp,
        output wr_ready
    );
endinterface

// File: rtl/seven_seg_scan_ctrl.sv
// Time-multiplexed 7-segment scan controller.
// Each digit slot is a guard gap (all digits off) followed by the driven digit.
// New values arrive through the write interface and are held pending until the
// frame boundary, so a frame never mixes old and new digits.
// Optional feature: define SEVEN_SEG_LZ_BLANK_EN for leading-zero blanking.

package seven_seg_pkg;
    // Segment patterns, bit order g..a, 1 = segment lit.
    typedef enum logic [6:0] {
        BLANK = 7'h00,
        ZERO  = 7'h3F,
        ONE   = 7'h06,
        TWO   = 7'h5B,
        THREE = 7'h4F,
        FOUR  = 7'h66,
        FIVE  = 7'h6D,
        SIX   = 7'h7D,
        SEVEN = 7'h07,
        EIGHT = 7'h7F,
        NINE  = 7'h6F,
        A     = 7'h77,
        B     = 7'h7C,
        C     = 7'h39,
        D     = 7'h5E,
        E     = 7'h79,
        F     = 7'h71
    } seven_seg_t;

    function automatic seven_seg_t hex_to_seg(input logic [3:0] nib);
        case (nib)
            4'h0:    return ZERO;
            4'h1:    return ONE;
            4'h2:    return TWO;
            4'h3:    return THREE;
            4'h4:    return FOUR;
            4'h5:    return FIVE;
            4'h6:    return SIX;
            4'h7:    return SEVEN;
            4'h8:    return EIGHT;
            4'h9:    return NINE;
            4'hA:    return A;
            4'hB:    return B;
            4'hC:    return C;
            4'hD:    return D;
            4'hE:    return E;
            4'hF:    return F;
            default: return BLANK;
        endcase
    endfunction
endpackage

module seven_seg_scan_ctrl
    import seven_seg_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int DIGIT_CYCLES = 1000,
    parameter int GUARD_CYCLES = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    seven_seg_scan_ctrl_if.slave   wr,
    input  logic                   blank_en,
    output logic [6:0]             seg_o,
    output logic                   dp_o,
    output logic [NUM_DIGITS-1:0]  an_o,
    output logic                   frame_done
);

    localparam int CNT_MAX = (DIGIT_CYCLES > GUARD_CYCLES) ? DIGIT_CYCLES : GUARD_CYCLES;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam int DIG_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    typedef enum logic {
        S_GAP,
        S_DRIVE
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [DIG_W-1:0]        r_dig;
    logic [DIG_W-1:0]        w_dig_nxt;
    logic [CNT_W-1:0]        r_cnt;
    logic [CNT_W-1:0]        w_cnt_nxt;
    logic                    w_wrap;

    logic [4*NUM_DIGITS-1:0] r_active_data;
    logic [NUM_DIGITS-1:0]   r_active_dp;
    logic [4*NUM_DIGITS-1:0] r_pend_data;
    logic [NUM_DIGITS-1:0]   r_pend_dp;
    logic                    r_pend_valid;
    logic                    r_wr_ready;
    logic                    w_accept;
    logic                    w_commit;
    logic                    w_pend_valid_nxt;

    seven_seg_t              w_seg_nxt;
    logic                    w_dp_nxt;
    logic [NUM_DIGITS-1:0]   w_an_nxt;
    logic [6:0]              r_seg;
    logic                    r_dp;
    logic [NUM_DIGITS-1:0]   r_an;
    logic                    r_frame_done;

    // Scan state register: FSM state, digit index and slot counter.
    // NOTE: sequential blocks use non-blocking assignments so every flop
    // samples the values from before the edge, independent of block order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_GAP;
            r_dig   <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_dig   <= w_dig_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Next-state logic: gap then drive per slot; the last digit's drive end is the frame wrap.
    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned, which would infer a latch.
    always_comb begin
        w_state_nxt = r_state;
        w_dig_nxt   = r_dig;
        w_cnt_nxt   = r_cnt + 1'b1;
        w_wrap      = 1'b0;
        case (r_state)
            S_GAP: begin
                if (r_cnt == CNT_W'(GUARD_CYCLES - 1)) begin
                    w_state_nxt = S_DRIVE;
                    w_cnt_nxt   = '0;
                end
            end
            S_DRIVE: begin
                if (r_cnt == CNT_W'(DIGIT_CYCLES - 1)) begin
                    w_state_nxt = S_GAP;
                    w_cnt_nxt   = '0;
                    if (r_dig == DIG_W'(NUM_DIGITS - 1)) begin
                        w_dig_nxt = '0;
                        w_wrap    = 1'b1;
                    end else begin
                        w_dig_nxt = r_dig + 1'b1;
                    end
                end
            end
            default: begin
                w_state_nxt = S_GAP;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    assign w_accept         = wr.wr_valid && r_wr_ready;
    assign w_commit         = w_wrap && r_pend_valid;
    assign w_pend_valid_nxt = w_accept || (r_pend_valid && !w_commit);

    // Display value registers: capture offered value into pending, move it to active at the wrap.
    // Accept and commit are mutually exclusive: accept needs pending empty, commit needs it full.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_active_data <= '0;
            r_active_dp   <= '0;
            r_pend_data   <= '0;
            r_pend_dp     <= '0;
            r_pend_valid  <= 1'b0;
            r_wr_ready    <= 1'b1;
        end else begin
            if (w_accept) begin
                r_pend_data <= wr.wr_data;
                r_pend_dp   <= wr.wr_dp;
            end
            if (w_commit) begin
                r_active_data <= r_pend_data;
                r_active_dp   <= r_pend_dp;
            end
            r_pend_valid <= w_pend_valid_nxt;
            r_wr_ready   <= !w_pend_valid_nxt;
        end
    end

    // Output pattern for the state being entered; blank_en only masks the drivers.
    always_comb begin
        w_seg_nxt = BLANK;
        w_dp_nxt  = 1'b0;
        w_an_nxt  = '0;
        if ((w_state_nxt == S_DRIVE) && !blank_en) begin
            w_an_nxt  = NUM_DIGITS'(1) << w_dig_nxt;
            w_seg_nxt = hex_to_seg(r_active_data[{w_dig_nxt, 2'b00} +: 4]);
            w_dp_nxt  = r_active_dp[w_dig_nxt];
`ifdef SEVEN_SEG_LZ_BLANK_EN
            // This nibble and everything above it zero: a leading zero, except digit 0.
            if ((w_dig_nxt != '0) && ((r_active_data >> {w_dig_nxt, 2'b00}) == '0)) begin
                w_seg_nxt = BLANK;
            end
`endif
        end
    end

    // Output registers: nothing combinational reaches the pins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_seg        <= 7'h00;
            r_dp         <= 1'b0;
            r_an         <= '0;
            r_frame_done <= 1'b0;
        end else begin
            r_seg        <= w_seg_nxt;
            r_dp         <= w_dp_nxt;
            r_an         <= w_an_nxt;
            r_frame_done <= w_wrap;
        end
    end

    assign seg_o       = r_seg;
    assign dp_o        = r_dp;
    assign an_o        = r_an;
    assign frame_done  = r_frame_done;
    assign wr.wr_ready = r_wr_ready;

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// Bench for seven_seg_scan_ctrl. The reference model derives the display from
// elapsed cycles since reset (frame/slot/phase arithmetic) and applies the
// commit rule at frame-boundary edges. Honours SEVEN_SEG_LZ_BLANK_EN.
module tb_seven_seg_scan_ctrl;

    localparam int ND    = 4;
    localparam int DC    = 4;
    localparam int GC    = 1;
    localparam int SLOT  = GC + DC;
    localparam int FRAME = ND * SLOT;

    logic clk;
    logic rst_n;
    logic blank_en;
    logic [6:0]    seg_o;
    logic          dp_o;
    logic [ND-1:0] an_o;
    logic          frame_done;

    seven_seg_scan_ctrl_if #(.NUM_DIGITS(ND)) wr_if ();

    seven_seg_scan_ctrl #(
        .NUM_DIGITS  (ND),
        .DIGIT_CYCLES(DC),
        .GUARD_CYCLES(GC)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .wr         (wr_if),
        .blank_en   (blank_en),
        .seg_o      (seg_o),
        .dp_o       (dp_o),
        .an_o       (an_o),
        .frame_done (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Segment patterns for hex 0..F, g..a.
    logic [6:0] seg_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                 7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state.
    int              m_k;
    logic [4*ND-1:0] m_active;
    logic [ND-1:0]   m_active_dp;
    logic [4*ND-1:0] m_pend;
    logic [ND-1:0]   m_pend_dp;
    logic            m_pv;
    logic            m_blank;
    logic            m_accepted;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s cycle=%0d got=%0h expected=%0h", tag, m_k, act, exp);
        end
    endtask

    task automatic model_reset();
        m_k         = 0;
        m_active    = '0;
        m_active_dp = '0;
        m_pend      = '0;
        m_pend_dp   = '0;
        m_pv        = 1'b0;
        m_blank     = 1'b0;
    endtask

    // Outputs expected in the current cycle, from position in the frame.
    task automatic expected(output logic [6:0] seg, output logic dp, output logic [ND-1:0] an);
        int s;
        int d;
        int ph;
        logic [3:0] nib;
        s   = m_k % FRAME;
        d   = s / SLOT;
        ph  = s % SLOT;
        seg = 7'h00;
        dp  = 1'b0;
        an  = '0;
        if (ph >= GC && !m_blank) begin
            an  = ND'(1 << d);
            nib = m_active[4*d +: 4];
            seg = seg_tab[nib];
`ifdef SEVEN_SEG_LZ_BLANK_EN
            if (d != 0 && (m_active >> (4*d)) == '0) seg = 7'h00;
`endif
            dp  = m_active_dp[d];
        end
    endtask

    // Check current outputs, take one clock edge, advance the model.
    task automatic cycle();
        logic [6:0]    e_seg;
        logic          e_dp;
        logic [ND-1:0] e_an;
        logic          boundary;
        logic          accept;
        expected(e_seg, e_dp, e_an);
        check("seg_o", 32'(seg_o), 32'(e_seg));
        check("an_o", 32'(an_o), 32'(e_an));
        check("dp_o", 32'(dp_o), 32'(e_dp));
        check("wr_ready", 32'(wr_if.wr_ready), 32'(!m_pv));
        check("frame_done", 32'(frame_done), 32'((m_k > 0) && (m_k % FRAME == 0)));
        @(posedge clk);
        boundary = ((m_k + 1) % FRAME == 0);
        accept   = wr_if.wr_valid && !m_pv;
        if (boundary && m_pv) begin
            m_active    = m_pend;
            m_active_dp = m_pend_dp;
            m_pv        = 1'b0;
        end
        if (accept) begin
            m_pend    = wr_if.wr_data;
            m_pend_dp = wr_if.wr_dp;
            m_pv      = 1'b1;
        end
        m_accepted = accept;
        m_blank    = blank_en;
        m_k++;
        @(negedge clk);
    endtask

    // Offer a value and hold it until accepted, with a cycle budget.
    task automatic write_word(input logic [4*ND-1:0] data, input logic [ND-1:0] dp);
        bit done;
        done             = 1'b0;
        wr_if.wr_valid   = 1'b1;
        wr_if.wr_data    = data;
        wr_if.wr_dp      = dp;
        for (int i = 0; i < 3 * FRAME && !done; i++) begin
            cycle();
            done = m_accepted;
        end
        check("write_accept_timeout", 32'(done), 32'd1);
        wr_if.wr_valid = 1'b0;
    endtask

    // Run until the model reaches a given digit/phase, with a cycle budget.
    task automatic run_to(input int digit, input int phase);
        bit hit;
        hit = 1'b0;
        for (int i = 0; i < 2 * FRAME && !hit; i++) begin
            if ((m_k % FRAME) / SLOT == digit && (m_k % SLOT) == phase) hit = 1'b1;
            else cycle();
        end
        check("run_to_timeout", 32'(hit), 32'd1);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rst_seg_o", 32'(seg_o), 32'h0);
        check("rst_an_o", 32'(an_o), 32'h0);
        check("rst_dp_o", 32'(dp_o), 32'h0);
        check("rst_frame_done", 32'(frame_done), 32'h0);
        check("rst_wr_ready", 32'(wr_if.wr_ready), 32'h1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    initial begin
        rst_n          = 1'b0;
        blank_en       = 1'b0;
        wr_if.wr_valid = 1'b0;
        wr_if.wr_data  = '0;
        wr_if.wr_dp    = '0;
        model_reset();
        apply_reset();

        // Reset release: ZERO on digit 0, then the scan moves on.
        repeat (12) cycle();

        // Commit at boundary, mid-frame write.
        write_word(16'h1A3F, 4'b0010);
        repeat (2 * FRAME) cycle();

        // Back-pressure: second write stalls until after the commit.
        write_word(16'h1111, 4'b0000);
        write_word(16'h2222, 4'b1000);
        repeat (2 * FRAME + 5) cycle();

        // blank_en during digit 2 drive for 30 cycles.
        run_to(2, GC + 1);
        blank_en = 1'b1;
        repeat (30) cycle();
        blank_en = 1'b0;
        repeat (FRAME) cycle();

        // Leading-zero cases.
        write_word(16'h0070, 4'b0000);
        repeat (2 * FRAME) cycle();
        write_word(16'h0000, 4'b0101);
        repeat (2 * FRAME) cycle();

        // Randomized traffic.
        for (int i = 0; i < 1500; i++) begin
            wr_if.wr_valid = ($urandom_range(0, 5) == 0);
            case ($urandom_range(0, 3))
                0:       wr_if.wr_data = 16'($urandom);
                1:       wr_if.wr_data = 16'($urandom) & 16'h00FF;
                2:       wr_if.wr_data = 16'($urandom) & 16'h0F0F;
                default: wr_if.wr_data = 16'h0000;
            endcase
            wr_if.wr_dp = 4'($urandom);
            if ($urandom_range(0, 40) == 0) blank_en = ~blank_en;
            cycle();
        end
        wr_if.wr_valid = 1'b0;
        blank_en       = 1'b0;
        repeat (2 * FRAME) cycle();

        // Reset during digit 3 with a write pending.
        run_to(0, GC + 1);
        write_word(16'hBEEF, 4'b1111);
        run_to(3, GC + 2);
        apply_reset();
        repeat (2 * FRAME) cycle();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/seven_seg_scan_ctrl.md
# seven_seg_scan_ctrl

Time-multiplexed scan controller for a bank of common-anode/cathode 7-segment digits sharing one segment bus. Holds a hex value per digit, decodes each nibble with the `seven_seg_pkg::seven_seg_t` encodings, and cycles the shared segment lines through the digits. Each digit slot starts with an anti-ghosting guard gap. New display values are accepted through a valid/ready handshake and committed only at frame boundaries, so a frame never shows a mix of old and new digits.

## Interface
- `NUM_DIGITS`, 4: digits scanned, ≥1.
- `DIGIT_CYCLES`, 1000: clock cycles a digit is driven per slot, ≥1.
- `GUARD_CYCLES`, 8: clock cycles with all digits off before each digit is driven, ≥1.

Ports:
- `clk` in 1: the only clock.
- `rst_n` in 1: reset, asynchronous assert, active-low.
- `wr_valid` in 1: a new display value is offered.
- `wr_ready` out 1: the block can accept a new value.
- `wr_data` in 4·NUM_DIGITS: hex nibbles; digit i is `[4i+3:4i]`, and digit 0 is the least significant.
- `wr_dp` in NUM_DIGITS: decimal point for each digit.
- `blank_en` in 1: forces the display dark.
- `seg_o` out 7: segment pattern, bit order g..a.
- `dp_o` out 1: decimal point.
- `an_o` out NUM_DIGITS: one-hot digit enable, active-high.
- `frame_done` out 1: one-cycle pulse at each frame boundary.

## Operation
- **Registers**
  - `active` (data + dp): the value being displayed.
  - `pending` (data + dp) with a `pending_valid` flag.
  - Digit index `dig`, slot counter `cnt`, and a 2-state FSM.
- **FSM states**
  - GAP: `an_o`=0, `seg_o`=BLANK, `dp_o`=0. Lasts GUARD_CYCLES, then goes to DRIVE.
  - DRIVE: `an_o`=1<<`dig`, `seg_o`=decode(`active` nibble `dig`), `dp_o`=`active_dp[dig]`. Lasts DIGIT_CYCLES, then goes to GAP.
- **Digit advance**
  - On DRIVE→GAP, `dig` increments.
  - When `dig` is NUM_DIGITS-1, it wraps to 0. This is the frame boundary.
- **Decode**
  - 0–9 map to ZERO..NINE; A–F map to A..F.
  - Values are `seven_seg_pkg` constants. Literal patterns are not used.
- **Handshake**
  - `wr_ready` = !`pending_valid`, registered.
  - A transfer occurs when `wr_valid` && `wr_ready` at a clock edge. It loads `pending` and sets `pending_valid`.
- **Commit**
  - At the frame-boundary edge, if `pending_valid` is set: `active` ← `pending` and `pending_valid` is cleared.
  - A write accepted on the boundary edge itself is not committed until the next frame.
- **`blank_en`**
  - While high: `an_o`=0, `seg_o`=BLANK, `dp_o`=0.
  - The FSM, counters, handshake, commit and `frame_done` keep running unchanged.
- `frame_done` is high for exactly the first GAP cycle of digit 0 after each wrap. It does not fire after reset.

## Timing
- **Reset values**
  - `seg_o`=7'h00, `dp_o`=0, `an_o`=0, `wr_ready`=1, `frame_done`=0.
  - `active`=0 and `pending_valid`=0.
  - FSM in GAP, `dig`=0, `cnt`=0.
- All outputs are registered. An output changes on the edge that enters the new state, with no combinational path from inputs to outputs.
- Slot length is GUARD_CYCLES+DIGIT_CYCLES. Frame length is NUM_DIGITS×(GUARD_CYCLES+DIGIT_CYCLES).
- After reset release, digit 0 is driven from cycle GUARD_CYCLES onward, showing ZERO (7'h3F).
- `wr_ready` falls on the edge after acceptance. It rises on the edge after commit.
- Write-to-display latency:
  - Minimum: 1 cycle plus the time to the next boundary.
  - Maximum: one full frame plus the first GAP of digit 0.
- `blank_en` takes effect on the next edge, in both directions.
- Reset asserted mid-frame clears everything immediately, including any `pending` value. Scanning restarts from digit 0 GAP.

## Configuration
- `SEVEN_SEG_LZ_BLANK_EN` defined: leading-zero blanking.
  - During DRIVE, a digit whose nibble is 0 and whose higher digits in `active` are all 0 shows BLANK.
  - Digit 0 is never blanked.
  - Its `dp_o` still follows `active_dp`.
- Not defined: every digit shows its decoded nibble.

## Test plan
Default bench uses NUM_DIGITS=4, DIGIT_CYCLES=4, GUARD_CYCLES=1.
- **Reset:** release `rst_n` → all outputs 0 for 1 cycle; then `an_o`=4'b0001 and `seg_o`=7'h3F for 4 cycles; then `an_o`=0 for 1 cycle; then `an_o`=4'b0010.
- **Commit at boundary:** write 16'h1A3F mid-frame → `wr_ready` low next cycle and the old value persists through the frame. After `frame_done` (period 20 cycles), digits 0..3 show 7'h71, 7'h4F, 7'h77, 7'h06.
- **Back-pressure:** write 16'h1111 then hold `wr_valid` with 16'h2222 → second write stalls until the edge after commit. The 1111 frame shows in full, then 2222 one frame later.
- **`blank_en`:** assert during DRIVE of digit 2 for 30 cycles → `an_o`=0 and `seg_o`=0 from next cycle. `frame_done` still pulses every 20 cycles. Deassert → the in-progress slot resumes at its current `cnt`.
- **Leading-zero blanking** (with `SEVEN_SEG_LZ_BLANK_EN`):
  - 16'h0070 → digits 3 and 2 show 7'h00, digit 1 shows 7'h07, digit 0 shows 7'h3F.
  - 16'h0000 → only digit 0 shows 7'h3F.
  - Without the macro, 16'h0070 shows 7'h3F, 7'h3F, 7'h07, 7'h3F.
- **Reset mid-operation:** pulse `rst_n` low during digit 3 with a write pending → all outputs 0 immediately, `wr_ready`=1, the pending value is discarded, and the display restarts as in the reset scenario.
